// File: rtl/pe_scheduler.sv
// pe_scheduler: dispatches layered tasks onto a PE bank with a per-layer completion barrier.
// Optional cycle/stall counters when PE_SCHED_PERF_EN is defined.
module pe_scheduler #(
  parameter int NUM_PE          = 4,
  parameter int NUM_LAYERS      = 3,
  parameter int TASKS_PER_LAYER = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NUM_PE-1:0]      pe_done,
  output logic [NUM_PE-1:0]      pe_start,
  output logic [NUM_PE*32-1:0]   pe_num,
  output logic [31:0]            layer_num,
  output logic                   busy,
  output logic                   layer_done,
  output logic                   done
`ifdef PE_SCHED_PERF_EN
  ,
  output logic [31:0]            cycle_count,
  output logic [31:0]            stall_count
`endif
);
  localparam int TW = $clog2(TASKS_PER_LAYER + 1);
  localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int SW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int CW = $clog2(NUM_PE + 1);
  typedef enum logic [1:0] {IDLE, DISPATCH, WAIT_LAYER, FINISH} state_t;
  state_t state;
  logic [NUM_PE-1:0] pe_busy, hits;
  logic [TW-1:0] issued, completed;
  logic [LW-1:0] layer;
  logic [SW-1:0] sel;
  logic [CW-1:0] n_hits;
  logic found, go;

  assign hits = pe_done & pe_busy;
  assign go = start && (state == IDLE || state == FINISH);
  assign layer_num = 32'(layer);

  // lowest-index idle PE; idleness is the registered mask, so a PE freed this cycle waits one cycle
  always_comb begin
    sel = '0;
    found = 1'b0;
    n_hits = '0;
    for (int i = NUM_PE - 1; i >= 0; i--) begin
      if (!pe_busy[i]) begin
        sel = SW'(i);
        found = 1'b1;
      end
      n_hits = n_hits + CW'(hits[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      pe_start <= '0;
      pe_num <= '0;
      layer <= '0;
      pe_busy <= '0;
      issued <= '0;
      completed <= '0;
      busy <= 1'b0;
      layer_done <= 1'b0;
      done <= 1'b0;
    end else begin
      pe_start <= '0;
      layer_done <= 1'b0;
      pe_busy <= pe_busy & ~hits;
      completed <= completed + TW'(n_hits);
      case (state)
        IDLE, FINISH: if (go) begin
          state <= DISPATCH;
          layer <= '0;
          issued <= '0;
          completed <= '0;
          pe_busy <= '0;
          busy <= 1'b1;
          done <= 1'b0;
        end
        DISPATCH: if (issued == TW'(TASKS_PER_LAYER)) begin
          state <= WAIT_LAYER;
        end else if (found) begin
          pe_start[sel] <= 1'b1;
          pe_num[32*sel +: 32] <= 32'(issued);
          pe_busy[sel] <= 1'b1;
          issued <= issued + 1'b1;
        end
        // layer_done is held for its pulse cycle so layer_num still names the finished layer
        WAIT_LAYER: if (layer_done) begin
          issued <= '0;
          completed <= '0;
          if (layer == LW'(NUM_LAYERS - 1)) begin
            state <= FINISH;
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            layer <= layer + 1'b1;
            state <= DISPATCH;
          end
        end else if (completed == TW'(TASKS_PER_LAYER)) begin
          layer_done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PE_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_count <= '0;
      stall_count <= '0;
    end else if (go) begin
      cycle_count <= '0;
      stall_count <= '0;
    end else begin
      if (busy && cycle_count != '1) cycle_count <= cycle_count + 1'b1;
      if (state == DISPATCH && issued < TW'(TASKS_PER_LAYER) && !found && stall_count != '1)
        stall_count <= stall_count + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_pe_scheduler.sv
// tb_pe_scheduler: scoreboarded random/directed bench with responder PEs and a timeline reference model.
module tb_pe_scheduler;
  localparam int NP = 4, NL = 3, NT = 8;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [NP-1:0] pe_done = '0, pe_start;
  logic [NP*32-1:0] pe_num;
  logic [31:0] layer_num;
  logic busy, layer_done, done;
  logic s_start = 1'b0;
  logic [0:0] s_pe_done = '0, s_pe_start;
  logic [31:0] s_pe_num, s_layer_num;
  logic s_busy, s_layer_done, s_done;
`ifdef PE_SCHED_PERF_EN
  logic [31:0] cycle_count, stall_count, s_cycle_count, s_stall_count;
`endif

  int tests = 0, fails = 0, cyc = 0, mode = 0, en_edge = 0;
  int m_layer = 0, m_issued = 0, layer_last = 0, busy_cycles = 0, m_stall = 0, ld_cyc = 0, n_starts = 0;
  int done_at[NP], dlen[NP];
  bit active = 0, got_done = 0, hit = 0, prev_done = 0;
  int exp_start_q[$], exp_ld_q[$], exp_done_q[$];

  always #5 clk = ~clk;

  pe_scheduler #(.NUM_PE(NP), .NUM_LAYERS(NL), .TASKS_PER_LAYER(NT)) dut (
    .clk(clk), .rst(rst), .start(start), .pe_done(pe_done), .pe_start(pe_start), .pe_num(pe_num),
    .layer_num(layer_num), .busy(busy), .layer_done(layer_done), .done(done)
`ifdef PE_SCHED_PERF_EN
    , .cycle_count(cycle_count), .stall_count(stall_count)
`endif
  );

  pe_scheduler #(.NUM_PE(1), .NUM_LAYERS(1), .TASKS_PER_LAYER(1)) dut_small (
    .clk(clk), .rst(rst), .start(s_start), .pe_done(s_pe_done), .pe_start(s_pe_start), .pe_num(s_pe_num),
    .layer_num(s_layer_num), .busy(s_busy), .layer_done(s_layer_done), .done(s_done)
`ifdef PE_SCHED_PERF_EN
    , .cycle_count(s_cycle_count), .stall_count(s_stall_count)
`endif
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int lat_for(int pe, int l, int t);
    case (mode)
      1: return (pe == 2 && l == 0) ? 20 : 5;
      2: return (l == 0 && t < 4) ? (pe == 1 ? 5 : pe == 3 ? 3 : 10) : 4;
      4: return int'($urandom_range(1, 9));
      default: return 5;
    endcase
  endfunction

  // Reference timeline: a PE whose done is first driven at negedge d is freed at edge d+1
  // and can be dispatched from edge d+2; dispatch is mandatory whenever a PE is free.
  initial begin
    int elig, idx, e, t4;
    logic [NP-1:0] pd;
    t4 = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (busy) busy_cycles++;
      elig = -1;
      for (int i = NP - 1; i >= 0; i--) if (done_at[i] + 2 <= cyc) elig = i;
      if (active && m_layer < NL && cyc >= en_edge && m_issued < NT) begin
        if (elig < 0) m_stall++;
        else check("dispatch_when_pe_free", pe_start != '0, 1);
      end
      if (pe_start != '0) begin
        idx = 0;
        for (int i = NP - 1; i >= 0; i--) if (pe_start[i]) idx = i;
        n_starts++;
        check("start_onehot", $countones(pe_start), 1);
        check("busy_at_start", busy, 1);
        check("start_in_window", active && m_layer < NL && cyc >= en_edge && m_issued < NT, 1);
        check("start_expected", exp_start_q.size() != 0, 1);
        if (exp_start_q.size() != 0) begin
          e = exp_start_q.pop_front();
          check("pe_num", pe_num[idx*32 +: 32], e % 1000);
          check("layer_num_at_start", layer_num, e / 1000);
          check("pe_choice", idx, elig);
          if (mode == 2 && e == 4) begin
            check("prio_first_pe1", idx, 1);
            t4 = cyc;
          end
          if (mode == 2 && e == 5) begin
            check("prio_second_pe3", idx, 3);
            check("prio_gap", cyc - t4, 1);
          end
          if (e == 1005) hit = 1;
        end
        done_at[idx] = cyc + lat_for(idx, m_layer, m_issued);
        dlen[idx] = (mode == 3 && idx == 0) ? 2 : (mode == 4) ? int'($urandom_range(1, 2)) : 1;
        if (done_at[idx] > layer_last) layer_last = done_at[idx];
        m_issued++;
      end
      if (layer_done) begin
        check("ld_expected", exp_ld_q.size() != 0, 1);
        if (exp_ld_q.size() != 0) check("ld_layer", layer_num, exp_ld_q.pop_front());
        check("ld_barrier", m_issued == NT && cyc >= layer_last + 2 && cyc <= layer_last + 3, 1);
        ld_cyc = cyc;
        m_layer++;
        m_issued = 0;
        layer_last = 0;
        en_edge = cyc + 2;
      end
      if (done && !prev_done) begin
        check("done_expected", exp_done_q.size() != 0, 1);
        if (exp_done_q.size() != 0) check("done_layers", m_layer, exp_done_q.pop_front());
        check("done_after_ld", cyc - ld_cyc, 1);
        check("busy_low_at_done", busy, 0);
`ifdef PE_SCHED_PERF_EN
        check("cycle_count", cycle_count, busy_cycles);
        check("stall_count", stall_count, m_stall);
`endif
        got_done = 1;
      end
      prev_done = done;
      for (int i = 0; i < NP; i++) pd[i] = (cyc >= done_at[i]) && (cyc < done_at[i] + dlen[i]);
      if (mode == 3 && done_at[2] + dlen[2] <= cyc && cyc % 4 == 0) pd[2] = 1'b1;
      pe_done = pd;
    end
  end

  task automatic prep_and_start(input int md);
    mode = md;
    for (int i = 0; i < NP; i++) begin
      done_at[i] = -100;
      dlen[i] = 1;
    end
    m_layer = 0;
    m_issued = 0;
    layer_last = 0;
    m_stall = 0;
    got_done = 0;
    hit = 0;
    for (int l = 0; l < NL; l++) begin
      exp_ld_q.push_back(l);
      for (int t = 0; t < NT; t++) exp_start_q.push_back(l * 1000 + t);
    end
    exp_done_q.push_back(NL);
    @(negedge clk);
    #1;
    start = 1'b1;
    active = 1;
    busy_cycles = 0;
    en_edge = cyc + 2;
    @(negedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run(input int md);
    prep_and_start(md);
    for (int i = 0; i < 3000 && !got_done; i++) begin
      @(negedge clk);
      if (md == 4 && i == 10) begin
        #1 start = 1'b1;
        @(negedge clk);
        #1 start = 1'b0;
      end
    end
    check("run_completes", got_done, 1);
    check("starts_drained", exp_start_q.size(), 0);
    check("ld_drained", exp_ld_q.size(), 0);
    check("done_held", done, 1);
    active = 0;
  endtask

  task automatic reset_test();
    int n0;
    prep_and_start(0);
    for (int i = 0; i < 500 && !hit; i++) @(negedge clk);
    check("reached_l1_t5", hit, 1);
    #2 rst = 1'b0;
    #1;
    check("rst_pe_start", pe_start, 0);
    check("rst_pe_num", pe_num, 0);
    check("rst_layer_num", layer_num, 0);
    check("rst_busy", busy, 0);
    check("rst_layer_done", layer_done, 0);
    check("rst_done", done, 0);
    active = 0;
    exp_start_q.delete();
    exp_ld_q.delete();
    exp_done_q.delete();
    for (int i = 0; i < NP; i++) done_at[i] = -100;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    n0 = n_starts;
    repeat (12) @(negedge clk);
    check("no_start_after_rst", n_starts - n0, 0);
    check("idle_after_rst", {busy, done}, 0);
  endtask

  task automatic small_test();
    int st_c, ld_c, dn_c, n_st, n_ld, bcy;
    st_c = -1; ld_c = -1; dn_c = -1; n_st = 0; n_ld = 0; bcy = 0;
    @(negedge clk);
    #1 s_start = 1'b1;
    for (int i = 0; i < 60 && dn_c < 0; i++) begin
      @(negedge clk);
      #1;
      s_start = 1'b0;
      if (s_busy) bcy++;
      if (s_pe_start[0]) begin
        n_st++;
        st_c = i;
        check("s_pe_num", s_pe_num, 0);
      end
      if (s_layer_done) begin
        n_ld++;
        ld_c = i;
        check("s_ld_layer", s_layer_num, 0);
      end
      if (s_done) dn_c = i;
      s_pe_done[0] = (st_c >= 0 && i == st_c + 3);
    end
    check("s_single_start", n_st, 1);
    check("s_single_ld", n_ld, 1);
    check("s_order", st_c >= 0 && ld_c > st_c && dn_c > ld_c, 1);
    check("s_busy_low", s_busy, 0);
`ifdef PE_SCHED_PERF_EN
    check("s_cycle_count", s_cycle_count, bcy);
    check("s_stall_count", s_stall_count, 0);
`endif
  endtask

  initial begin
    for (int i = 0; i < NP; i++) begin
      done_at[i] = -100;
      dlen[i] = 1;
    end
    repeat (3) @(negedge clk);
    #1;
    check("reset_pe_start", pe_start, 0);
    check("reset_pe_num", pe_num, 0);
    check("reset_layer_num", layer_num, 0);
    check("reset_busy", busy, 0);
    check("reset_layer_done", layer_done, 0);
    check("reset_done", done, 0);
    rst = 1'b1;
    @(negedge clk);
    run(0);
    run(1);
    run(2);
    run(3);
    reset_test();
    run(0);
    repeat (4) run(4);
    small_test();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish before 2000000");
    $fatal(1, "timeout");
  end
endmodule
